// File: rtl/membus_arbiter_pkg.sv
// rtl/membus_arbiter_pkg.sv - shared types and constants for the memory bus arbiter
//
// Contents:
//   arb_state_t   arbiter FSM states (IDLE, GNT_MEM, GNT_IF, DONE)
//   mem_access_t  MEM-stage access kind (read, write, IO in, IO out)
//   bus_attr_t    bus write / IO-space attributes of an access
//   TIMEOUT_DEFAULT, WAIT_W  bus wait limit and wait counter width
//   decode_mem()  resolves simultaneous MEM strobes to one access kind
//   access_attr() maps an access kind onto bus_we / bus_io
package membus_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GNT_MEM = 2'd1,
    GNT_IF  = 2'd2,
    DONE    = 2'd3
  } arb_state_t;

  typedef enum logic [1:0] {
    ACC_READ  = 2'd0,
    ACC_WRITE = 2'd1,
    ACC_IN    = 2'd2,
    ACC_OUT   = 2'd3
  } mem_access_t;

  typedef struct packed {
    logic we;
    logic io;
  } bus_attr_t;

  localparam int unsigned TIMEOUT_DEFAULT = 15;
  localparam int unsigned WAIT_W          = 4;

  // Priority when several strobes are up together: out > in > write > read.
  function automatic mem_access_t decode_mem(input logic rd, input logic wr,
                                             input logic io_in, input logic io_out);
    mem_access_t acc;
    acc = ACC_READ;
    if (io_out)     acc = ACC_OUT;
    else if (io_in) acc = ACC_IN;
    else if (wr)    acc = ACC_WRITE;
    else if (rd)    acc = ACC_READ;
    return acc;
  endfunction

  function automatic bus_attr_t access_attr(input mem_access_t acc);
    bus_attr_t attr;
    attr.we = (acc == ACC_WRITE) || (acc == ACC_OUT);
    attr.io = (acc == ACC_IN)    || (acc == ACC_OUT);
    return attr;
  endfunction

endpackage

// File: rtl/membus_arbiter_bus_wait_timer.sv
// rtl/membus_arbiter_bus_wait_timer.sv - bus wait counter with timeout compare
//
// Ports:
//   clk       system clock
//   rst       asynchronous active-low reset
//   clear     hold the counter at zero (asserted whenever no grant is active)
//   count_en  one more cycle spent waiting for bus_ack
//   expired   this waiting cycle is the TIMEOUT-th one; abort at the next edge
module bus_wait_timer
  import membus_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic count_en,
  output logic expired
);

  localparam logic [WAIT_W-1:0] LAST_WAIT = WAIT_W'(TIMEOUT - 1);

  logic [WAIT_W-1:0] count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (count_en) begin
      count <= count + 1'b1;
    end
  end

  // Firing on the last waiting cycle (count still TIMEOUT-1) keeps bus_req
  // high for exactly TIMEOUT cycles before the abort takes effect.
  assign expired = count_en && (count == LAST_WAIT);

endmodule

// File: rtl/membus_arbiter.sv
// rtl/membus_arbiter.sv - shared memory bus arbiter between fetch and MEM stage
//
// Ports:
//   clk, rst                     clock, asynchronous active-low reset
//   if_req/if_addr               fetch read request (level, held until if_done)
//   if_rdata/if_done             fetched word and one-cycle completion pulse
//   mem_R/mem_W/mem_in/mem_out   MEM-stage read/write/IO-in/IO-out strobes
//   mem_addr/mem_wdata           MEM-stage address and store data
//   mem_rdata/mem_done           load data and one-cycle completion pulse
//   stallreq_if/stallreq_mem     stall requests while an access is outstanding
//   bus_req/bus_we/bus_io        bus request, write, IO-space select
//   bus_addr/bus_wdata           bus address and write data
//   bus_rdata/bus_ack            bus read data and acknowledge
//   bus_err                      one-cycle pulse when an access times out
module membus_arbiter
  import membus_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_done,
  input  logic        mem_R,
  input  logic        mem_W,
  input  logic        mem_in,
  input  logic        mem_out,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        mem_done,
  output logic        stallreq_if,
  output logic        stallreq_mem,
  output logic        bus_req,
  output logic        bus_we,
  output logic        bus_io,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack,
  output logic        bus_err
);

  arb_state_t state;
  logic       mem_any;
  logic       in_grant;
  logic       timer_expired;
  bus_attr_t  mem_attr;

  assign mem_any  = mem_R | mem_W | mem_in | mem_out;
  assign in_grant = (state == GNT_MEM) || (state == GNT_IF);
  assign mem_attr = access_attr(decode_mem(mem_R, mem_W, mem_in, mem_out));

  // The counter is held clear outside grant states, so every grant entry
  // starts counting from zero.
  bus_wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_wait_timer (
    .clk      (clk),
    .rst      (rst),
    .clear    (!in_grant),
    .count_en (in_grant && !bus_ack),
    .expired  (timer_expired)
  );

  // Gated by rst so the stall lines fall together with bus_req during reset.
  assign stallreq_mem = rst && mem_any && !mem_done;
  assign stallreq_if  = rst && if_req  && !if_done;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_io    <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      bus_err   <= 1'b0;
      if_rdata  <= '0;
      if_done   <= 1'b0;
      mem_rdata <= '0;
      mem_done  <= 1'b0;
    end else begin
      if_done  <= 1'b0;
      mem_done <= 1'b0;
      bus_err  <= 1'b0;

      case (state)
        IDLE: begin
          // MEM wins ties: it belongs to the older instruction.
          if (mem_any) begin
            state     <= GNT_MEM;
            bus_req   <= 1'b1;
            bus_we    <= mem_attr.we;
            bus_io    <= mem_attr.io;
            bus_addr  <= mem_addr;
            bus_wdata <= mem_wdata;
          end else if (if_req) begin
            state     <= GNT_IF;
            bus_req   <= 1'b1;
            bus_we    <= 1'b0;
            bus_io    <= 1'b0;
            bus_addr  <= if_addr;
            bus_wdata <= '0;
          end
        end

        // Requests are not re-examined here: a withdrawn request still runs
        // the bus cycle to completion and still gets its done pulse.
        GNT_MEM, GNT_IF: begin
          if (bus_ack || timer_expired) begin
            state   <= DONE;
            bus_req <= 1'b0;
            bus_err <= !bus_ack;
            if (state == GNT_MEM) begin
              mem_done <= 1'b1;
              if (!bus_we) mem_rdata <= bus_ack ? bus_rdata : 32'h0;
            end else begin
              if_done  <= 1'b1;
              if_rdata <= bus_ack ? bus_rdata : 32'h0;
            end
          end
        end

        DONE: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/membus_arbiter.md
MEMBUS_ARBITER -- requirements
Module: membus_arbiter

Interface
REQ-001 Parameter: TIMEOUT, default 15, maximum bus wait cycles per access before forced abort.
REQ-002 Clocking SHALL be one clock; reset is asynchronous and active-low.
REQ-003 clk  in  1  system clock, all state on rising edge.
REQ-004 rst  in  1  asynchronous active-low reset.
REQ-005 if_req  in  1  instruction-fetch read request, level, held until if_done.
REQ-006 if_addr  in  32  fetch address.
REQ-007 if_rdata  out  32  fetched word, valid with if_done.
REQ-008 if_done  out  1  one-cycle completion pulse to fetch.
REQ-009 mem_R, mem_W, mem_in, mem_out  in  1 each  MEM-stage data read, data write, IO read, IO write, held until mem_done.
REQ-010 mem_addr, mem_wdata  in  32 each  MEM-stage address and store data.
REQ-011 mem_rdata  out  32  load/IO-in data, valid with mem_done.
REQ-012 mem_done  out  1  one-cycle completion pulse to MEM stage.
REQ-013 stallreq_if, stallreq_mem  out  1 each  stall requests to the stall controller.
REQ-014 bus_req, bus_we, bus_io  out  1 each  shared bus request, write, IO-space select.
REQ-015 bus_addr, bus_wdata  out  32 each  bus address and write data; bus_rdata in 32; bus_ack in 1.
REQ-016 bus_err  out  1  one-cycle pulse on timeout abort.

Function
REQ-017 FSM states SHALL be IDLE, GNT_MEM, GNT_IF, DONE.
REQ-018 IDLE: any MEM request -> GNT_MEM; else if_req -> GNT_IF; else stay.
REQ-019 Simultaneous MEM and IF requests SHALL grant MEM first (older instruction).
REQ-020 On grant entry, bus_req=1 with bus_addr/bus_we/bus_io/bus_wdata registered from the granted requester, held stable until ack or abort.
REQ-021 Write = mem_W or mem_out; IO = mem_in or mem_out; fetch is read, non-IO.
REQ-022 Multiple MEM strobes asserted together SHALL resolve priority mem_out > mem_in > mem_W > mem_R.
REQ-023 bus_ack sampled high in a grant state: latch bus_rdata (reads), drop bus_req, go to DONE.
REQ-024 Minimum access latency: request in IDLE at cycle 0, bus_req at 1, ack at 1 -> done pulse at cycle 2.
REQ-025 DONE lasts exactly one cycle: pulses the granted requester's done, then IDLE (one turnaround cycle between accesses).
REQ-026 4-bit wait counter clears on grant entry, increments each grant cycle without ack; reaching TIMEOUT -> drop bus_req, pulse bus_err, rdata=0, go to DONE.
REQ-027 stallreq_mem = MEM request asserted and mem_done not asserted this cycle; stallreq_if likewise for if_req/if_done.
REQ-028 Request withdrawn while granted SHALL NOT abort the bus cycle; completion proceeds, done still pulses.
REQ-029 Write accesses SHALL leave rdata outputs unchanged.

Reset
REQ-030 rst low SHALL immediately force IDLE, all outputs and counter to 0, including mid-access (bus_req drops asynchronously).
REQ-031 After rst release, first grant SHALL occur no earlier than the first rising edge with a request sampled.

Structure
REQ-032 State encodings, TIMEOUT default, and ReadEnable/WriteEnable/In/Out constants SHALL live in the shared defines.v.
REQ-033 One sub-module, bus_wait_timer (counter + timeout compare), is natural; the FSM stays in membus_arbiter.

Verification
REQ-034 if_req, addr 0x0000_0040, ack after 2 cycles, rdata 0x2402_0005 -> if_rdata=0x2402_0005, if_done pulse 1 cycle, stallreq_if high until it.
REQ-035 mem_W and if_req same cycle, mem_addr 0x100, wdata 0xDEAD_BEEF -> write granted first (bus_we=1), fetch granted after DONE+IDLE.
REQ-036 mem_in, addr 0x8, ack immediate, rdata 0x55 -> bus_io=1, mem_rdata=0x55, done at cycle 2.
REQ-037 mem_R, no ack -> bus_req drops after 15 wait cycles, bus_err and mem_done pulse, mem_rdata=0.
REQ-038 rst low mid-GNT_MEM -> bus_req and stall requests 0 same cycle; state IDLE after release.
